serial_add_ctrl: RTL and testbench

Bit-serial adder sequencer that time-multiplexes a single 1-bit full-adder cell across WIDTH bit positions. It accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake and shifts the operands LSB-first through the cell, one bit per cycle, keeping the carry in a flop. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the area-minimal adder for the arithmetic datapath wherever latency is not critical.

---
 rtl/serial_arith_pkg.sv | 17 +
 rtl/serial_add_ctrl_fa_cell.sv | 21 ++
 rtl/serial_add_ctrl.sv | 148 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t   : sequencer states (IDLE, RUN, DONE)
//   WIDTH_DEF : default operand width of the serial adder
// -----------------------------------------------------------------------------
package serial_arith_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
// Purely combinational 1-bit full adder, the only arithmetic in the serial adder.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit      (a ^ b ^ ci)
//   co   : carry out    (majority of a, b, ci)
// -----------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder sequencer. One full-adder cell is reused across WIDTH bit
// positions, LSB first, one bit per clock, with the carry held in a flop.
// Result = (a + b + cin) mod 2^WIDTH plus carry out of the top bit.
// Latency accept -> result is WIDTH cycles; one op per WIDTH+2 cycles max.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b, cin           : operands, sampled only at the accept edge
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, cout           : result, held stable while out_valid is high
//   busy                : high in RUN or DONE
// All outputs come from registers or a decode of the state register.
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    // Sized so that WIDTH=1 still gets a 1-bit counter.
    localparam int              CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt == LAST);

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at
    // the LSB. A 1-bit sum register simply takes the cell output.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_nxt = fa_s;
        end else begin : g_sum_wn
            assign sum_nxt = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; in_valid only matters in IDLE, so operands arriving
    // during RUN/DONE are dropped rather than queued.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, carry flop, bit counter and sum accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nxt;
            carry  <= fa_co;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_sh;
    assign cout      = carry;

    // Handshake sanity properties
    a_no_ready_and_valid: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && out_valid));

    a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state == DONE && !out_ready) |=> ($stable(sum) && $stable(cout) && out_valid));

    a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        (state == RUN) |-> (cnt <= LAST));

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [W-1:0] a, b, sum;

    logic         in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
    logic [0:0]   a1, b1, sum1;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // reference model state
    int           m_phase = 0;   // 0 idle, 1 computing, 2 result available
    int           m_left  = 0;
    logic [W:0]   m_exp   = '0;
    int           acc_last = 0;
    int           ov_rise  = 0;
    logic         ov_prev  = 1'b0;
    int           acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: result appears W edges after accept, stays until taken.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_sum", 32'(sum), 32'd0);
            chk("rst_cout", 32'(cout), 32'd0);
        end else begin
            chk("m_in_ready", 32'(in_ready), 32'(m_phase == 0));
            chk("m_out_valid", 32'(out_valid), 32'(m_phase == 2));
            chk("m_busy", 32'(busy), 32'(m_phase != 0));
            if (m_phase == 2) chk("m_result", 32'({cout, sum}), 32'(m_exp));
            if (out_valid && !ov_prev) ov_rise = cyc;
            case (m_phase)
                0: if (in_valid) begin
                    m_phase = 1;
                    m_left  = W;
                    m_exp   = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
                    acc_last = cyc + 1;
                    acc_q.push_back(cyc + 1);
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
        ov_prev = out_valid;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
        int k = 0;
        a = av; b = bv; cin = c; in_valid = 1'b1;
        while (!in_ready && k < 50) begin tick(); k++; end
        if (k >= 50) chk("accept_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_ov;
        int k = 0;
        while (!out_valid && k < 50) begin tick(); k++; end
        if (k >= 50) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0;
        in_valid1 = 0; out_ready1 = 1; a1 = '0; b1 = '0; cin1 = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_w1_in_ready", 32'(in_ready1), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1: 0x0F + 0x01
        out_ready = 1'b1;
        do_accept(8'h0F, 8'h01, 1'b0);
        wait_ov();
        @(negedge clk); #1;
        chk("t1_sum", 32'(sum), 32'h10);
        chk("t1_cout", 32'(cout), 32'd0);
        chk("t1_latency", 32'(ov_rise - acc_last), 32'd8);
        tick(); tick();

        // 2: carry ripple cases
        do_accept(8'hFF, 8'h01, 1'b0);
        wait_ov();
        chk("t2a_sum", 32'(sum), 32'h00);
        chk("t2a_cout", 32'(cout), 32'd1);
        tick();
        do_accept(8'hFF, 8'hFF, 1'b1);
        wait_ov();
        chk("t2b_sum", 32'(sum), 32'hFF);
        chk("t2b_cout", 32'(cout), 32'd1);
        tick();

        // 3: backpressure, new operands offered meanwhile
        out_ready = 1'b0;
        do_accept(8'h3C, 8'h5A, 1'b1);
        wait_ov();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            tick();
            chk("t3_out_valid", 32'(out_valid), 32'd1);
            chk("t3_in_ready", 32'(in_ready), 32'd0);
            chk("t3_sum", 32'(sum), 32'h97);
            chk("t3_cout", 32'(cout), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3_in_ready_after", 32'(in_ready), 32'd1);
        chk("t3_out_valid_after", 32'(out_valid), 32'd0);

        // 4: reset in the middle of a computation
        do_accept(8'hAA, 8'h55, 1'b0);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_sum", 32'(sum), 32'd0);
        chk("t4_cout", 32'(cout), 32'd0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("t4_ready_after", 32'(in_ready), 32'd1);
        do_accept(8'h05, 8'h03, 1'b0);
        wait_ov();
        chk("t4_sum_after", 32'(sum), 32'h08);
        chk("t4_cout_after", 32'(cout), 32'd0);
        tick();

        // 5: back-to-back with both handshakes held high
        acc_q.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int k = 0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            while (!in_ready && k < 50) begin tick(); k++; end
            if (k >= 50) chk("t5_accept_timeout", 32'd0, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        wait_ov();
        tick(); tick();
        chk("t5_accept_count", 32'(acc_q.size()), 32'd4);
        for (int i = 1; i < acc_q.size(); i++)
            chk("t5_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd10);

        // 6: WIDTH=1 instance, all input combinations
        for (int i = 0; i < 8; i++) begin
            int e;
            e = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
            a1 = 1'((i >> 2) & 1); b1 = 1'((i >> 1) & 1); cin1 = 1'(i & 1);
            chk("w1_in_ready", 32'(in_ready1), 32'd1);
            in_valid1 = 1'b1;
            tick();
            in_valid1 = 1'b0;
            chk("w1_busy", 32'(busy1), 32'd1);
            tick();
            chk("w1_out_valid", 32'(out_valid1), 32'd1);
            chk("w1_result", 32'({cout1, sum1}), 32'(e));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
